// File: rtl/ltl_monitor_cluster.sv
// Runtime-verification monitor cluster top: registers the trace into the automata stage,
// reduces report lines to per-property verdicts, and tracks violations (sticky, counters, event queue).
module ltl_monitor_cluster #(
  parameter int NUM_PROPS        = 9,
  parameter int REPORTS_PER_PROP = 4,
  parameter int SYM_W            = 8,
  parameter int CNT_W            = 16,
  parameter int TS_W             = 32,
  parameter int FIFO_DEPTH       = 8,
  parameter int PID_W            = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 run,
  input  logic [SYM_W-1:0]                     symbols,
  output logic [SYM_W-1:0]                     stage_symbols,
  output logic                                 stage_run,
  input  logic [NUM_PROPS*REPORTS_PER_PROP-1:0] stage_reports,
  input  logic [NUM_PROPS-1:0]                 prop_mask,
  input  logic                                 clear,
  output logic [NUM_PROPS-1:0]                 ltl_out,
  output logic [NUM_PROPS-1:0]                 ltl_sticky,
  output logic                                 evt_valid,
  input  logic                                 evt_ready,
  output logic [NUM_PROPS-1:0]                 evt_props,
  output logic [TS_W-1:0]                      evt_ts,
  output logic                                 evt_overflow,
  input  logic [PID_W-1:0]                     cnt_sel,
  output logic [CNT_W-1:0]                     cnt_value
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int EVT_W = NUM_PROPS + TS_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0 -> p1: trace symbol and step enable into the automata stage
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_symbols <= '0;
      stage_run     <= 1'b0;
    end else begin
      stage_run <= run;
      if (run) stage_symbols <= symbols;
    end
  end

  logic [NUM_PROPS-1:0] fire;
  always_comb begin
    fire = '0;
    for (int p = 0; p < NUM_PROPS; p++)
      fire[p] = (|stage_reports[p*REPORTS_PER_PROP +: REPORTS_PER_PROP]) & prop_mask[p] & stage_run;
  end

  logic [TS_W-1:0] ts;

  // Stage p1 -> p2: verdicts, sticky flags and the trace-step timestamp
  always_ff @(posedge clk) begin
    if (reset) begin
      ltl_out    <= '0;
      ltl_sticky <= '0;
      ts         <= '0;
    end else begin
      ltl_out    <= fire;
      ltl_sticky <= clear ? fire : (ltl_sticky | fire);
      if (stage_run) ts <= ts + 1'b1;
    end
  end

  logic [CNT_W-1:0] cnt [NUM_PROPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PROPS; p++) cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PROPS; p++) begin
        if (clear)        cnt[p] <= CNT_W'(fire[p]);
        else if (fire[p]) cnt[p] <= sat_inc(cnt[p]);
      end
    end
  end

  // Out-of-range selects fall through to zero
  logic [CNT_W-1:0] cnt_mux;
  always_comb begin
    cnt_mux = '0;
    for (int p = 0; p < NUM_PROPS; p++)
      if (cnt_sel == PID_W'(p)) cnt_mux = cnt[p];
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_value <= '0;
    else       cnt_value <= cnt_mux;
  end

  logic [EVT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             empty, full, push_req, pop, push_ok, drop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push_req = |fire;
  assign pop      = !empty && evt_ready;
  // A simultaneous pop frees the slot, so a push into a full queue still lands
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= {fire, ts};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (clear)     evt_overflow <= drop;
      else if (drop) evt_overflow <= 1'b1;
    end
  end

  assign evt_valid           = !empty;
  assign {evt_props, evt_ts} = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_ltl_monitor_cluster.sv
// Self-checking bench for ltl_monitor_cluster: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_ltl_monitor_cluster;

  localparam int NP = 9;
  localparam int RP = 4;
  localparam int CW = 4;
  localparam int DEPTH = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            run = 1'b0;
  logic [7:0]      symbols = '0;
  logic [7:0]      stage_symbols;
  logic            stage_run;
  logic [NP*RP-1:0] reports = '0;
  logic [NP-1:0]   prop_mask = '1;
  logic            clear = 1'b0;
  logic [NP-1:0]   ltl_out, ltl_sticky, evt_props;
  logic            evt_valid, evt_ready = 1'b0, evt_overflow;
  logic [31:0]     evt_ts;
  logic [3:0]      cnt_sel = '0;
  logic [CW-1:0]   cnt_value;

  int checks = 0;
  int failures = 0;

  ltl_monitor_cluster #(
    .NUM_PROPS(NP), .REPORTS_PER_PROP(RP), .SYM_W(8), .CNT_W(CW),
    .TS_W(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols),
    .stage_symbols(stage_symbols), .stage_run(stage_run),
    .stage_reports(reports), .prop_mask(prop_mask), .clear(clear),
    .ltl_out(ltl_out), .ltl_sticky(ltl_sticky),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_props(evt_props),
    .evt_ts(evt_ts), .evt_overflow(evt_overflow),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  typedef struct { bit [NP-1:0] props; bit [31:0] ts; } evt_t;

  // Behavioural model state
  evt_t      m_q[$];
  bit [7:0]  m_sym;
  bit        m_run;
  bit [NP-1:0] m_ltl, m_sticky;
  int        m_cnt[NP];
  int        m_cntval;
  bit [31:0] m_ts;
  bit        m_ovf;
  bit        model_live = 0;

  task automatic model_step();
    bit [NP-1:0] f;
    bit pop, drop;
    int sz;
    evt_t e;
    if (reset) begin
      m_q.delete();
      m_sym = '0; m_run = 0; m_ltl = '0; m_sticky = '0; m_cntval = 0;
      m_ts = '0; m_ovf = 0;
      for (int p = 0; p < NP; p++) m_cnt[p] = 0;
      model_live = 1;
      return;
    end
    f = '0;
    if (m_run)
      for (int p = 0; p < NP; p++)
        if (prop_mask[p] && ((reports >> (p*RP)) & 36'hF) != 0) f[p] = 1;
    m_cntval = (int'(cnt_sel) < NP) ? m_cnt[cnt_sel] : 0;
    sz = m_q.size();
    pop = (sz > 0) && evt_ready;
    drop = 0;
    if (pop) void'(m_q.pop_front());
    if (f != 0) begin
      if (sz < DEPTH || pop) begin
        e.props = f; e.ts = m_ts;
        m_q.push_back(e);
      end else drop = 1;
    end
    m_ovf = clear ? drop : (m_ovf | drop);
    for (int p = 0; p < NP; p++) begin
      if (clear) m_cnt[p] = f[p] ? 1 : 0;
      else if (f[p]) m_cnt[p] = (m_cnt[p] >= CMAX) ? CMAX : m_cnt[p] + 1;
    end
    m_sticky = clear ? f : (m_sticky | f);
    m_ltl = f;
    if (m_run) m_ts = m_ts + 1;
    if (run) m_sym = symbols;
    m_run = run;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (model_live) begin
      chk("stage_symbols", 64'(stage_symbols), 64'(m_sym));
      chk("stage_run", 64'(stage_run), 64'(m_run));
      chk("ltl_out", 64'(ltl_out), 64'(m_ltl));
      chk("ltl_sticky", 64'(ltl_sticky), 64'(m_sticky));
      chk("cnt_value", 64'(cnt_value), 64'(m_cntval));
      chk("evt_valid", 64'(evt_valid), 64'(m_q.size() > 0));
      chk("evt_props", 64'(evt_props), m_q.size() > 0 ? 64'(m_q[0].props) : 64'd0);
      chk("evt_ts", 64'(evt_ts), m_q.size() > 0 ? 64'(m_q[0].ts) : 64'd0);
      chk("evt_overflow", 64'(evt_overflow), 64'(m_ovf));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NP*RP-1:0] rep_bit(input int b);
    logic [NP*RP-1:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  initial begin
    int n;
    logic [31:0] prev_ts;

    // Reset
    step(2);
    chk("rst_evt_valid", 64'(evt_valid), 0);
    chk("rst_ltl_out", 64'(ltl_out), 0);
    chk("rst_cnt_value", 64'(cnt_value), 0);
    chk("rst_stage_run", 64'(stage_run), 0);
    reset = 0;

    // First trace: prop 0 report bit 3 sampled when the timestamp is 5
    run = 1; symbols = 8'h5A; cnt_sel = 0;
    step(6);
    reports = rep_bit(3);
    step();
    reports = '0;
    chk("t1_ltl_out", 64'(ltl_out), 64'h001);
    chk("t1_evt_valid", 64'(evt_valid), 1);
    chk("t1_evt_props", 64'(evt_props), 64'h001);
    chk("t1_evt_ts", 64'(evt_ts), 5);
    chk("t1_model_ts", 64'(m_q[0].ts), 5);
    chk("t1_stage_symbols", 64'(stage_symbols), 64'h5A);
    step();
    chk("t1_cnt0", 64'(cnt_value), 1);

    // Props 2 and 7 together (with clear, so sticky holds only these)
    evt_ready = 1; step(); evt_ready = 0;
    reports = rep_bit(9) | rep_bit(30); clear = 1;
    step();
    reports = '0; clear = 0;
    chk("t2_evt_props", 64'(evt_props), 64'h084);
    chk("t2_sticky", 64'(ltl_sticky), 64'h084);
    evt_ready = 1; step(); evt_ready = 0;
    prop_mask = 9'h17F;
    reports = rep_bit(9) | rep_bit(30);
    step();
    reports = '0; prop_mask = '1;
    chk("t2_masked_props", 64'(evt_props), 64'h004);
    chk("t2_masked_ltl", 64'(ltl_out), 64'h004);
    evt_ready = 1; step(); evt_ready = 0;

    // Overflow: nine pushes into an eight-entry queue
    reports = rep_bit(0);
    step(9);
    reports = '0;
    step();
    chk("t3_overflow", 64'(evt_overflow), 1);
    evt_ready = 1;
    prev_ts = '0;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain_valid", 64'(evt_valid), 1);
      if (i > 0) chk("t3_ts_ascending", 64'(evt_ts), 64'(prev_ts + 32'd1));
      prev_ts = evt_ts;
      step();
    end
    chk("t3_drained", 64'(evt_valid), 0);
    evt_ready = 0;

    // Full queue with simultaneous pop and push
    clear = 1; step(); clear = 0;
    chk("t4_ovf_cleared", 64'(evt_overflow), 0);
    reports = rep_bit(0);
    step(8);
    evt_ready = 1;
    step();
    reports = '0; evt_ready = 0;
    chk("t4_no_overflow", 64'(evt_overflow), 0);
    evt_ready = 1;
    n = 0;
    for (int i = 0; i < 20 && evt_valid; i++) begin
      n++;
      step();
    end
    chk("t4_occupancy", 64'(n), 8);
    evt_ready = 0;

    // Counter saturation, clear with fire, out-of-range select
    evt_ready = 1; cnt_sel = 1;
    reports = rep_bit(4);
    step(20);
    reports = '0;
    step(2);
    chk("t5_cnt_sat", 64'(cnt_value), 15);
    clear = 1; reports = rep_bit(5);
    step();
    clear = 0; reports = '0;
    chk("t5_sticky1", 64'(ltl_sticky[1]), 1);
    step();
    chk("t5_cnt_clear_fire", 64'(cnt_value), 1);
    cnt_sel = 9;
    step();
    chk("t5_cnt_sel_oob", 64'(cnt_value), 0);
    evt_ready = 0;

    // Reports ignored while the stage is idle
    run = 0; step();
    reports = '1;
    step(3);
    chk("t6_idle_ltl", 64'(ltl_out), 0);
    chk("t6_idle_valid", 64'(evt_valid), 0);
    reports = '0; run = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      reports = rep_bit(0); step();
      reports = '0; step();
    end
    chk("t6_queued", 64'(evt_valid), 1);
    reset = 1;
    step();
    chk("t6_rst_valid", 64'(evt_valid), 0);
    chk("t6_rst_props", 64'(evt_props), 0);
    chk("t6_rst_ts", 64'(evt_ts), 0);
    chk("t6_rst_sticky", 64'(ltl_sticky), 0);
    chk("t6_rst_ovf", 64'(evt_overflow), 0);
    chk("t6_rst_sym", 64'(stage_symbols), 0);
    chk("t6_rst_cnt", 64'(cnt_value), 0);
    reset = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      symbols   = 8'($urandom);
      reports   = ($urandom_range(0, 1) == 0) ? '0 :
                  (NP*RP)'({$urandom, $urandom} & {$urandom, $urandom});
      prop_mask = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '1;
      clear     = ($urandom_range(0, 19) == 0);
      evt_ready = ($urandom_range(0, 1) == 0);
      cnt_sel   = 4'($urandom_range(0, 15));
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0; clear = 0; reports = '0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ltl_monitor_cluster.md
# ltl_monitor_cluster

Parametrised top-level for one runtime-verification monitor cluster. It registers the trace symbol stream into a cluster's automata stage and OR-reduces the stage's per-property report lines into one verdict per LTL property. It adds what the fixed-size cluster tops lack: per-property enable mask, sticky violation flags, saturating violation counters, and a timestamped violation event queue drained over a valid/ready handshake. It sits between the core trace tap and the monitor collector, one instance per cluster.

## Interface

- NUM_PROPS, 9: number of LTL properties in the cluster (1..32).
- REPORTS_PER_PROP, 4: report lines per property from the automata stage (≥1).
- SYM_W, 8: symbol width.
- CNT_W, 16: per-property violation counter width.
- TS_W, 32: cycle timestamp width.
- FIFO_DEPTH, 8: event queue entries, power of two, ≥2.
- PID_W (derived), clog2(NUM_PROPS), minimum 1.

- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  trace step enable.
- symbols  in  SYM_W  trace symbol for this step.
- stage_symbols  out  SYM_W  registered symbol to automata stage.
- stage_run  out  1  registered run to automata stage.
- stage_reports  in  NUM_PROPS*REPORTS_PER_PROP  report lines; property p owns bits [p*REPORTS_PER_PROP +: REPORTS_PER_PROP].
- prop_mask  in  NUM_PROPS  1 = property enabled.
- clear  in  1  clears sticky flags, counters, overflow.
- ltl_out  out  NUM_PROPS  registered per-property verdict.
- ltl_sticky  out  NUM_PROPS  sticky violation flags.
- evt_valid  out  1  event queue head valid.
- evt_ready  in  1  consumer accepts head.
- evt_props  out  NUM_PROPS  properties fired in the event cycle.
- evt_ts  out  TS_W  timestamp of the event.
- evt_overflow  out  1  sticky: an event was dropped.
- cnt_sel  in  PID_W  counter read select.
- cnt_value  out  CNT_W  selected counter value.

## Operation

- Symbol path: stage_symbols <= symbols when run=1 (hold otherwise); stage_run <= run.
- fire[p] = OR of property p's report lines AND prop_mask[p] AND stage_run. Reports are ignored whenever stage_run=0.
- ltl_out <= fire every cycle.
- Timestamp: internal TS_W counter, increments each cycle stage_run=1, wraps from all-ones to 0, holds otherwise.
- Sticky: ltl_sticky[p] <= 1 on fire[p]; cleared by clear. If clear and fire[p] occur in the same cycle, the result is 1.
- Counters: cnt[p] increments on fire[p] and saturates at 2^CNT_W−1. clear zeroes it; if clear and fire coincide, cnt[p]=1.
- Counter read: cnt_value <= cnt[cnt_sel]. cnt_sel ≥ NUM_PROPS yields 0.
- Event queue: push {fire, current timestamp} in any cycle where |fire=1. The head is presented on evt_props/evt_ts; evt_valid = not empty. A pop occurs on evt_valid & evt_ready.
- Full queue: a push is dropped and evt_overflow <= 1, unless a pop happens in the same cycle, in which case the push is accepted. clear resets evt_overflow but does not flush the queue. If clear and a dropped push coincide, evt_overflow=1.
- Queue drain (pops) is independent of run.
- Reset: stage_symbols=0, stage_run=0, ltl_out=0, ltl_sticky=0, all counters=0, cnt_value=0, timestamp=0, queue empty, evt_valid=0, evt_overflow=0. evt_props and evt_ts read 0 while empty. Reset asserted mid-operation discards queued events.

## Timing

- symbols → stage_symbols: 1 cycle.
- stage_reports → ltl_out, ltl_sticky, counter update: 1 cycle.
- stage_reports → evt_valid (empty queue): 1 cycle. evt_ts equals the timestamp value in the cycle the reports were sampled.
- cnt_sel → cnt_value: 1 cycle. A counter update in cycle N is visible on cnt_value at N+2.
- Pop at edge N presents the next entry at N+1. Back-to-back pops sustain 1 event per cycle.
- evt_props and evt_ts are stable while evt_valid=1 and evt_ready=0.

## Test plan

- Reset, then run=1 with symbols=0x5A and report bit 3 (prop 0) high at cycle 5 → ltl_out[0]=1 at cycle 6; evt_valid=1 with evt_props=0x001 and evt_ts=5 (counted from first run cycle 0); cnt[0]=1.
- Props 2 and 7 fire in the same cycle with prop_mask=0x1FF → a single event with evt_props=0x084; ltl_sticky=0x084. Repeat with prop_mask[7]=0 → evt_props=0x004.
- evt_ready=0, 9 fire cycles with FIFO_DEPTH=8 → 8 entries held, evt_overflow=1. Then evt_ready=1 → 8 pops in consecutive cycles with ascending timestamps.
- Queue full, and a pop and a push in the same cycle → push accepted, evt_overflow stays 0, occupancy stays 8.
- CNT_W=4, prop 1 fires 20 cycles → cnt_value=15 with cnt_sel=1. clear asserted together with a fire → cnt=1, ltl_sticky[1]=1. cnt_sel=9 → cnt_value=0.
- run=0 with reports held high → no fires, timestamp held, ltl_out=0. Reset asserted with 3 events queued → evt_valid=0 the next cycle and all outputs at their reset values.
